// File: rtl/riscv_test_ctrl_if.sv
// Monitored core bus: data-memory write port and retirement strobe.
// The core side drives, the test controller observes.
interface riscv_test_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            retire;
    logic [XLEN-1:0] pc;

    modport master (
        output mem_we, mem_addr, mem_wdata, retire, pc
    );

    modport slave (
        input mem_we, mem_addr, mem_wdata, retire, pc
    );
endinterface

// File: rtl/riscv_test_ctrl.sv
// Test controller: sequences core reset, watches for the tohost write,
// counts cycles/retirements and flags timeouts or tight self-loops.
module riscv_test_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              CNT_W        = 32,
    parameter int              RESET_CYCLES = 4,
    parameter int              MAX_CYCLES   = 1000,
    parameter int              LOOP_LIMIT   = 8,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = 'h100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    riscv_test_ctrl_if.slave     bus,
    output logic                 core_reset,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [XLEN-1:0]      fail_code,
    output logic                 timeout,
    output logic                 hang,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     instret_count
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int LW = $clog2(LOOP_LIMIT + 1);

    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [LW-1:0]    LOOP_MAX  = LW'(LOOP_LIMIT);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [HW-1:0]     hold_cnt, hold_cnt_n;
    logic [LW-1:0]     loop_cnt, loop_cnt_n;
    logic [XLEN-1:0]   last_pc, last_pc_n;
    logic              core_reset_n, done_n, pass_n, fail_n;
    logic              timeout_n, hang_n;
    logic [XLEN-1:0]   fail_code_n;
    logic [CNT_W-1:0]  cycle_n, instret_n;
    logic              tohost_hit;

    assign tohost_hit = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);

    always_comb begin
        state_n      = state;
        hold_cnt_n   = hold_cnt;
        loop_cnt_n   = loop_cnt;
        last_pc_n    = last_pc;
        core_reset_n = 1'b1;
        done_n       = done;
        pass_n       = pass;
        fail_n       = fail;
        fail_code_n  = fail_code;
        timeout_n    = timeout;
        hang_n       = hang;
        cycle_n      = cycle_count;
        instret_n    = instret_count;

        if (restart) begin
            state_n     = HOLD;
            hold_cnt_n  = '0;
            loop_cnt_n  = '0;
            last_pc_n   = '0;
            done_n      = 1'b0;
            pass_n      = 1'b0;
            fail_n      = 1'b0;
            fail_code_n = '0;
            timeout_n   = 1'b0;
            hang_n      = 1'b0;
            cycle_n     = '0;
            instret_n   = '0;
        end else begin
            unique case (state)
                HOLD: begin
                    hold_cnt_n = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt_n   = hold_cnt;
                        state_n      = RUN;
                        core_reset_n = 1'b0;
                    end
                end
                RUN: begin
                    core_reset_n = 1'b0;
                    cycle_n      = cycle_count + 1'b1;
                    if (bus.retire) begin
                        instret_n = instret_count + 1'b1;
                        if (bus.pc == last_pc) begin
                            loop_cnt_n = loop_cnt + 1'b1;
                        end else begin
                            loop_cnt_n = LW'(1);
                            last_pc_n  = bus.pc;
                        end
                    end
                    // Priority: tohost, then self-loop, then timeout.
                    if (tohost_hit) begin
                        state_n      = DONE;
                        core_reset_n = 1'b1;
                        done_n       = 1'b1;
                        if (bus.mem_wdata == XLEN'(1)) begin
                            pass_n = 1'b1;
                        end else begin
                            fail_n      = 1'b1;
                            fail_code_n = bus.mem_wdata >> 1;
                        end
                    end else if (bus.retire && loop_cnt_n == LOOP_MAX) begin
                        state_n      = DONE;
                        core_reset_n = 1'b1;
                        done_n       = 1'b1;
                        hang_n       = 1'b1;
                    end else if (cycle_count == CYC_LAST) begin
                        state_n      = DONE;
                        core_reset_n = 1'b1;
                        done_n       = 1'b1;
                        timeout_n    = 1'b1;
                    end
                end
                DONE: begin
                    core_reset_n = 1'b1;
                end
                default: begin
                    state_n = HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            loop_cnt      <= '0;
            last_pc       <= '0;
            core_reset    <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            fail_code     <= '0;
            timeout       <= 1'b0;
            hang          <= 1'b0;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_cnt_n;
            loop_cnt      <= loop_cnt_n;
            last_pc       <= last_pc_n;
            core_reset    <= core_reset_n;
            done          <= done_n;
            pass          <= pass_n;
            fail          <= fail_n;
            fail_code     <= fail_code_n;
            timeout       <= timeout_n;
            hang          <= hang_n;
            cycle_count   <= cycle_n;
            instret_count <= instret_n;
        end
    end

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Scoreboard bench for riscv_test_ctrl: directed and random run traces
// are scored by a trace-level reference model.
module tb_riscv_test_ctrl;

    localparam int XLEN = 32;
    localparam int CNT_W = 32;
    localparam int RC = 4;
    localparam int MAXC = 50;
    localparam int LL = 8;

    typedef struct {
        bit          pass;
        bit          fail;
        bit          timeout;
        bit          hang;
        logic [31:0] code;
        logic [31:0] cyc;
        logic [31:0] inst;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              restart;
    logic              core_reset, done, pass, fail, timeout, hang;
    logic [XLEN-1:0]   fail_code;
    logic [CNT_W-1:0]  cycle_count, instret_count;

    riscv_test_ctrl_if #(.XLEN(XLEN)) bus ();

    riscv_test_ctrl #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RESET_CYCLES(RC),
        .MAX_CYCLES(MAXC), .LOOP_LIMIT(LL), .TOHOST_ADDR(32'h100)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .bus(bus),
        .core_reset(core_reset), .done(done), .pass(pass),
        .fail(fail), .fail_code(fail_code), .timeout(timeout),
        .hang(hang), .cycle_count(cycle_count),
        .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    bit          t_we[MAXC];
    logic [31:0] t_addr[MAXC];
    logic [31:0] t_wd[MAXC];
    bit          t_ret[MAXC];
    logic [31:0] t_pc[MAXC];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: walk the trace cycle by cycle, first terminating rule wins.
    function automatic exp_t model();
        exp_t        e;
        int          run;
        logic [31:0] prev;
        e = '{default: 0};
        run = 0;
        prev = 32'hffff_ffff;
        for (int k = 0; k < MAXC; k++) begin
            e.cyc = k + 1;
            if (t_ret[k]) e.inst = e.inst + 1;
            if (t_we[k] && t_addr[k] == 32'h100) begin
                if (t_wd[k] == 1) e.pass = 1;
                else begin
                    e.fail = 1;
                    e.code = t_wd[k] / 2;
                end
                return e;
            end
            if (t_ret[k]) begin
                run = (run > 0 && t_pc[k] == prev) ? run + 1 : 1;
                prev = t_pc[k];
                if (run == LL) begin
                    e.hang = 1;
                    return e;
                end
            end
            if (k + 1 == MAXC) begin
                e.timeout = 1;
                return e;
            end
        end
        return e;
    endfunction

    task automatic clear_trace();
        for (int i = 0; i < MAXC; i++) begin
            t_we[i] = 0; t_addr[i] = 0; t_wd[i] = 0;
            t_ret[i] = 0; t_pc[i] = 0;
        end
    endtask

    task automatic set_ret(int c, logic [31:0] p);
        t_ret[c-1] = 1;
        t_pc[c-1] = p;
    endtask

    task automatic set_wr(int c, logic [31:0] a, logic [31:0] d);
        t_we[c-1] = 1;
        t_addr[c-1] = a;
        t_wd[c-1] = d;
    endtask

    task automatic drive_idle();
        bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
        bus.retire = 0; bus.pc = 0;
    endtask

    task automatic drive_junk();
        bus.mem_we = 1; bus.mem_addr = 32'h100;
        bus.mem_wdata = $urandom_range(0, 1);
        bus.retire = 1; bus.pc = 32'h40;
    endtask

    task automatic chk_cleared(string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_flags"}, {pass, fail, timeout, hang}, 0);
        chk({tag, "_code"}, fail_code, 0);
        chk({tag, "_cyc"}, cycle_count, 0);
        chk({tag, "_inst"}, instret_count, 0);
        chk({tag, "_core_rst"}, core_reset, 1);
    endtask

    task automatic hold_phase();
        for (int i = 0; i < RC - 1; i++) begin
            @(negedge clk);
            chk("hold_core_rst", core_reset, 1);
        end
    endtask

    // Restart pulse coincides with a tohost pass write: restart must win.
    task automatic do_restart();
        @(negedge clk);
        restart = 1;
        bus.mem_we = 1; bus.mem_addr = 32'h100; bus.mem_wdata = 1;
        @(negedge clk);
        restart = 0;
        drive_idle();
        chk_cleared("restart");
        hold_phase();
    endtask

    task automatic run_test(string tag);
        exp_t e;
        e = model();
        sb.push_back(e);
        for (int k = 1; k <= MAXC; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_run_core_rst"}, core_reset, 0);
                chk({tag, "_cyc_start"}, cycle_count, 0);
            end
            bus.mem_we = t_we[k-1]; bus.mem_addr = t_addr[k-1];
            bus.mem_wdata = t_wd[k-1];
            bus.retire = t_ret[k-1]; bus.pc = t_pc[k-1];
        end
        @(negedge clk);
        chk({tag, "_done_bound"}, done, 1);
        for (int i = 0; i < 3; i++) begin
            drive_junk();
            @(negedge clk);
        end
        drive_idle();
        chk({tag, "_frz_flags"}, {pass, fail, timeout, hang},
            {e.pass, e.fail, e.timeout, e.hang});
        chk({tag, "_frz_cyc"}, cycle_count, e.cyc);
        chk({tag, "_frz_inst"}, instret_count, e.inst);
        chk({tag, "_frz_code"}, fail_code, e.code);
        chk({tag, "_halt_core"}, core_reset, 1);
    endtask

    task automatic rand_trace();
        logic [31:0] p;
        logic [31:0] pcs[4];
        logic [31:0] adr[3];
        pcs = '{32'h40, 32'h44, 32'h48, 32'h80};
        adr = '{32'h100, 32'h104, 32'hfc};
        clear_trace();
        p = pcs[$urandom_range(0, 3)];
        for (int c = 1; c <= MAXC; c++) begin
            if ($urandom_range(0, 3) == 0) p = pcs[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) set_ret(c, p);
            if ($urandom_range(0, 39) == 0)
                set_wr(c, adr[$urandom_range(0, 2)],
                       $urandom_range(0, 1) ? 32'd1 : $urandom);
        end
    endtask

    bit prev_done = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 && !prev_done) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                chk("mon_pass", pass, e.pass);
                chk("mon_fail", fail, e.fail);
                chk("mon_timeout", timeout, e.timeout);
                chk("mon_hang", hang, e.hang);
                chk("mon_code", fail_code, e.code);
                chk("mon_cycles", cycle_count, e.cyc);
                chk("mon_instret", instret_count, e.inst);
            end
        end
        prev_done = (done === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        restart = 1;
        drive_idle();
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        reset = 0;
        restart = 0;
        hold_phase();

        clear_trace();
        for (int i = 0; i < 10; i++) set_ret(i + 1, 32'h1000 + 4 * i);
        set_wr(20, 32'h100, 1);
        run_test("pass20");

        do_restart();
        clear_trace();
        set_wr(5, 32'h104, 1);
        set_wr(12, 32'h100, 7);
        run_test("fail7");

        do_restart();
        clear_trace();
        for (int c = 3; c < 11; c++) set_ret(c, 32'h40);
        run_test("hang");

        do_restart();
        clear_trace();
        for (int c = 1; c <= MAXC; c++)
            set_ret(c, (c % 2) ? 32'h40 : 32'h44);
        run_test("alt_pc");

        do_restart();
        clear_trace();
        run_test("timeout");

        do_restart();
        clear_trace();
        set_wr(MAXC, 32'h100, 1);
        run_test("pass_last");

        do_restart();
        clear_trace();
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bus.retire = 1; bus.pc = 32'h200 + 4 * c;
        end
        do_restart();

        clear_trace();
        for (int c = 1; c <= 6; c++) set_ret(c, 32'h300 + 4 * c);
        set_wr(9, 32'h100, 1);
        run_test("post_abort");

        for (int n = 0; n < 20; n++) begin
            do_restart();
            rand_trace();
            run_test("rand");
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
